// File: rtl/d_flip_flop_if.sv
// Data-side bundle of the D flip-flop: capture enable, data in, and the
// true/complement outputs. The master drives en/d and observes q/qbar;
// the flip-flop itself sits on the slave side.
interface d_flip_flop_if #(
    parameter int WIDTH = 1
) ();

    logic             en;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] qbar;

    modport master (
        output en,
        output d,
        input  q,
        input  qbar
    );

    modport slave (
        input  en,
        input  d,
        output q,
        output qbar
    );

endinterface

// File: rtl/d_flip_flop.sv
// Edge-triggered D storage element with synchronous active-low reset and
// capture enable. q is the only state; qbar is derived from it so the two
// outputs can never disagree or be equal.
module d_flip_flop #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
    input  logic          clk,
    input  logic          rst_n,
    d_flip_flop_if.slave  bus
);

    logic [WIDTH-1:0] q_r;

    // Complement helper kept as a function so both output paths share one definition.
    function automatic logic [WIDTH-1:0] complement(input logic [WIDTH-1:0] value);
        return ~value;
    endfunction

    // State register: reset dominates enable, enable selects capture, otherwise hold.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_r <= RESET_VAL;
        end else if (bus.en) begin
            q_r <= bus.d;
        end else begin
            q_r <= q_r;
        end
    end

    assign bus.q    = q_r;
    assign bus.qbar = complement(q_r);

endmodule

// File: tb/tb_d_flip_flop.sv
// Self-checking bench for d_flip_flop: a 1-bit instance (RESET_VAL 0) and an
// 8-bit instance (RESET_VAL 8'hA5) share clock and reset and are checked
// against a simple "last captured value" reference model.
module tb_d_flip_flop;

    logic clk;
    logic rst_n;

    int checks_cnt;
    int errors_cnt;

    logic [0:0] m1;
    logic [7:0] m8;

    d_flip_flop_if #(.WIDTH(1)) bus1 ();
    d_flip_flop_if #(.WIDTH(8)) bus8 ();

    d_flip_flop #(.WIDTH(1), .RESET_VAL(1'b0)) u_dff1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1.slave)
    );

    d_flip_flop #(.WIDTH(8), .RESET_VAL(8'hA5)) u_dff8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus8.slave)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Compare both instances against the model (q and its complement).
    task automatic check_all(input string tag);
        check_val({tag, "_q1"},    {7'd0, bus1.q},    {7'd0, m1});
        check_val({tag, "_qbar1"}, {7'd0, bus1.qbar}, {7'd0, ~m1});
        check_val({tag, "_q8"},    bus8.q,            m8);
        check_val({tag, "_qbar8"}, bus8.qbar,         ~m8);
    endtask

    // Advance one rising edge: model takes what the flop should store given the
    // inputs present at the edge, then outputs are checked 1 ns later.
    task automatic step(input string tag);
        logic [0:0] n1;
        logic [7:0] n8;
        if (!rst_n) begin
            n1 = 1'b0;
            n8 = 8'hA5;
        end else begin
            n1 = bus1.en ? bus1.d : m1;
            n8 = bus8.en ? bus8.d : m8;
        end
        @(posedge clk);
        m1 = n1;
        m8 = n8;
        #1;
        check_all(tag);
    endtask

    task automatic drive(input logic r, input logic e, input logic [0:0] d1, input logic [7:0] d8);
        rst_n   = r;
        bus1.en = e;
        bus8.en = e;
        bus1.d  = d1;
        bus8.d  = d8;
    endtask

    initial begin
        checks_cnt = 0;
        errors_cnt = 0;
        m1 = 1'bx;
        m8 = 8'hxx;
        drive(1'b0, 1'b1, 1'b1, 8'hFF);
        #1;

        // Test 1 / 6: reset for two edges, then first capture.
        step("rst_a");
        step("rst_b");
        check_val("t1_q1_reset",    {7'd0, bus1.q},    8'h00);
        check_val("t1_qbar1_reset", {7'd0, bus1.qbar}, 8'h01);
        check_val("t6_q8_reset",    bus8.q,            8'hA5);
        check_val("t6_qbar8_reset", bus8.qbar,         8'h5A);
        drive(1'b1, 1'b1, 1'b1, 8'h3C);
        step("cap1");
        check_val("t1_q1_cap",    {7'd0, bus1.q},    8'h01);
        check_val("t1_qbar1_cap", {7'd0, bus1.qbar}, 8'h00);
        check_val("t6_q8_cap",    bus8.q,            8'h3C);
        check_val("t6_qbar8_cap", bus8.qbar,         8'hC3);

        // Test 2: 25 random captures with en=1 (250 ns).
        for (int i = 0; i < 25; i++) begin
            drive(1'b1, 1'b1, 1'($urandom), 8'($urandom));
            step("rand_en");
        end

        // Test 3: en=0, d toggles for 3 edges -> hold.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, ~bus1.d, ~bus8.d);
            step("hold");
        end

        // Test 4: q=1, then reset with d=1,en=1 on the same edge.
        drive(1'b1, 1'b1, 1'b1, 8'hFF);
        step("pre_rst");
        drive(1'b0, 1'b1, 1'b1, 8'hFF);
        step("rst_wins");
        check_val("t4_q1_rst_wins", {7'd0, bus1.q}, 8'h00);
        check_val("t4_q8_rst_wins", bus8.q,         8'hA5);

        // Test 5: mid-cycle d change does not reach q before the next edge.
        drive(1'b1, 1'b1, 1'b1, 8'h11);
        step("pre_mid");
        #1;
        drive(1'b1, 1'b1, 1'b0, 8'hEE);
        #2;
        check_all("mid_d");
        step("post_mid");

        // Mid-cycle reset assertion has no effect until the next edge.
        #1;
        rst_n = 1'b0;
        #2;
        check_all("mid_rst");
        step("post_mid_rst");

        // Mixed random traffic: occasional reset, random enable and data.
        for (int i = 0; i < 60; i++) begin
            drive(($urandom_range(0, 7) != 0), 1'($urandom), 1'($urandom), 8'($urandom));
            step("mixed");
        end

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
